// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // The loader itself: consumes bytes, issues memory writes.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  // Whatever feeds the loader and owns the instruction memory.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed byte stream (4-byte LE word
// count, N LE words, 1 XOR checksum byte), writes the words to instruction
// memory and holds the CPU pipeline in reset until a load checks out.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start after reset
// HDR    | collecting the 4 header bytes (word count N)
// DATA   | collecting payload words, one memory write per completed word
// CSUM   | waiting for the checksum byte
// DONE   | load good, CPU released from reset
// ERR    | load aborted (oversize count or checksum mismatch)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  imem_loader_if.slave  bus,
  output logic          cpu_rst_out_o,
  output logic          done_o,
  output logic          error_o,
  output logic [15:0]   words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state_q, state_d;

  logic        rx_ready;
  logic        accept;
  logic        start_ok;
  logic        last_byte;
  logic        last_word;
  logic        n_too_big;
  logic [31:0] word_asm;

  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic [7:0]  xor_q;
  logic [15:0] n_q;
  logic [15:0] wl_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Bytes arrive least significant first, so the newest byte lands on top.
  assign word_asm  = {bus.rx_data, shift_q};
  assign accept    = bus.rx_valid & rx_ready;
  assign last_byte = accept & (byte_cnt_q == 2'd3);
  assign last_word = ((wl_q + 16'd1) == n_q);
  assign n_too_big = (word_asm > 32'(MAX_WORDS));
  assign start_ok  = start_i &
                     ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside an active frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) state_d = S_HDR;
      end
      S_HDR: begin
        if (last_byte) begin
          if (word_asm == 32'd0) state_d = S_CSUM;
          else if (n_too_big)    state_d = S_ERR;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && last_word) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rx_ready      = 1'b0;
    done_o        = 1'b0;
    error_o       = 1'b0;
    cpu_rst_out_o = 1'b1;
    case (state_q)
      S_HDR, S_DATA, S_CSUM: rx_ready = 1'b1;
      S_DONE: begin
        done_o        = 1'b1;
        cpu_rst_out_o = 1'b0;
      end
      S_ERR:   error_o = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly, running checksum, word counting and the write port.
  // The write is registered so the strobe appears the cycle after the
  // word's last byte while the receiver keeps accepting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      xor_q      <= 8'd0;
      n_q        <= 16'd0;
      wl_q       <= 16'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      we_q <= 1'b0;
      if (start_ok) begin
        byte_cnt_q <= 2'd0;
        shift_q    <= 24'd0;
        xor_q      <= 8'd0;
        n_q        <= 16'd0;
        wl_q       <= 16'd0;
      end else if (accept && (state_q != S_CSUM)) begin
        shift_q    <= word_asm[31:8];
        byte_cnt_q <= byte_cnt_q + 2'd1;
        xor_q      <= xor_q ^ bus.rx_data;
        if ((state_q == S_HDR) && last_byte) begin
          n_q <= word_asm[15:0];
        end
        if ((state_q == S_DATA) && last_byte) begin
          we_q    <= 1'b1;
          wdata_q <= word_asm;
          addr_q  <= BASE_ADDR + {14'd0, wl_q, 2'b00};
          wl_q    <= wl_q + 16'd1;
        end
      end
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign words_loaded_o = wl_q;

endmodule
